// File: rtl/dram_uart_dump.sv
// Dumps a fixed DRAM address window as 8N1 UART frames on tx whenever the core's
// busy falls. While a dump runs, this block owns the DRAM read address.
module dram_uart_dump #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] START_ADDR   = 8'h00,
  parameter int         DUMP_LEN     = 256
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       busy,
  input  logic [7:0] Ddin,
  output logic [7:0] DAddress,
  output logic       dram_req,
  output logic       tx,
  output logic       active,
  output logic       done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [8:0]        LAST_BYTE = 9'(DUMP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_busyQ;
  logic [8:0]        r_byteCnt;
  logic [7:0]        r_addr;
  logic [7:0]        r_shreg;
  logic [BAUD_W-1:0] r_baudCnt;
  logic [2:0]        r_bitCnt;
  logic              r_tx;
  logic              r_active;
  logic              r_req;
  logic              r_done;

  state_t            w_stateNext;
  logic [8:0]        w_byteCntNext;
  logic [7:0]        w_addrNext;
  logic [7:0]        w_shregNext;
  logic [BAUD_W-1:0] w_baudNext;
  logic [2:0]        w_bitNext;
  logic              w_txNext;
  logic              w_activeNext;
  logic              w_reqNext;
  logic              w_doneNext;
  logic              w_trigger;
  logic              w_baudDone;

  assign w_trigger  = r_busyQ & ~busy;
  assign w_baudDone = (r_baudCnt == BAUD_LAST);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busyQ   <= 1'b0;
      r_byteCnt <= '0;
      r_addr    <= START_ADDR;
      r_shreg   <= '0;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_busyQ   <= busy;
      r_byteCnt <= w_byteCntNext;
      r_addr    <= w_addrNext;
      r_shreg   <= w_shregNext;
      r_baudCnt <= w_baudNext;
      r_bitCnt  <= w_bitNext;
      r_tx      <= w_txNext;
      r_active  <= w_activeNext;
      r_req     <= w_reqNext;
      r_done    <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_byteCntNext = r_byteCnt;
    w_addrNext    = r_addr;
    w_shregNext   = r_shreg;
    w_baudNext    = r_baudCnt + 1'b1;
    w_bitNext     = r_bitCnt;
    w_txNext      = 1'b1;
    w_activeNext  = r_active;
    w_reqNext     = r_req;
    w_doneNext    = r_done;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_trigger) begin
          w_stateNext   = S_READ;
          w_doneNext    = 1'b0;
          w_activeNext  = 1'b1;
          w_reqNext     = 1'b1;
          w_addrNext    = START_ADDR;
          w_byteCntNext = '0;
        end
      end
      S_READ: w_stateNext = S_WAIT;
      S_WAIT: w_stateNext = S_LOAD;
      S_LOAD: begin
        w_shregNext = Ddin;
        w_stateNext = S_START;
      end
      S_START: begin
        if (w_baudDone) w_stateNext = S_DATA;
      end
      S_DATA: begin
        if (w_baudDone) begin
          w_baudNext  = '0;
          w_shregNext = {1'b0, r_shreg[7:1]};
          if (r_bitCnt == 3'd7) w_stateNext = S_STOP;
          else                  w_bitNext   = r_bitCnt + 3'd1;
        end
      end
      S_STOP: begin
        if (w_baudDone) begin
          if (r_byteCnt == LAST_BYTE) begin
            w_stateNext  = S_DONE;
            w_activeNext = 1'b0;
            w_reqNext    = 1'b0;
            w_doneNext   = 1'b1;
          end else begin
            w_stateNext   = S_READ;
            w_byteCntNext = r_byteCnt + 9'd1;
            w_addrNext    = r_addr + 8'd1;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase

    // Every state starts with fresh baud/bit counts so frame timing never carries over.
    if (w_stateNext != r_state) begin
      w_baudNext = '0;
      w_bitNext  = '0;
    end

    case (w_stateNext)
      S_START: w_txNext = 1'b0;
      S_DATA:  w_txNext = w_shregNext[0];
      default: w_txNext = 1'b1;
    endcase
  end

  assign DAddress = r_addr;
  assign dram_req = r_req;
  assign tx       = r_tx;
  assign active   = r_active;
  assign done     = r_done;

endmodule
